alu_arbiter: RTL and testbench

//  Shares the single 10-bit combinational ALU (2-bit op) between two requesters
//  (e.g. fetch/address unit on port 0, execute unit on port 1).

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter in front of a shared combinational ALU
// One operation in flight: IDLE accepts, EXEC waits one cycle on the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int DATA_W = 10,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;

  logic                grant0, grant1;
  logic                owner_rsp_ready;

  // Pointer only breaks ties; a lone requester is always granted.
  assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1 = req1_valid & (~req0_valid |  ptr_q);

  assign req0_ready = (state_q == ST_IDLE) & grant0;
  assign req1_ready = (state_q == ST_IDLE) & grant1;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_ready) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          owner_d  = 1'b0;
          ptr_d    = 1'b1;
          state_d  = ST_EXEC;
        end else if (req1_ready) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          owner_d  = 1'b1;
          ptr_d    = 1'b0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp0_valid = rsp_valid_q & ~owner_q;
  assign rsp1_valid = rsp_valid_q &  owner_q;
  assign rsp_data   = rsp_data_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// ALU stand-in: op0 add, op1 sub, op2 and, op3 or (10-bit wrap).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [9:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [9:0] rsp_data, alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [1:0] op;
    logic [9:0] exp;
  } vec_t;
  vec_t sweep[16];

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      2'd0:    alu_result = alu_a + alu_b;
      2'd1:    alu_result = alu_a - alu_b;
      2'd2:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  alu_arbiter #(.DATA_W(10), .OP_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with the request already presented and rsp_ready held high.
  task automatic serve(input int port, input logic [9:0] exp_data, input string tag);
    check({tag, "_ready"}, (port == 1) ? req1_ready : req0_ready, 16'd1);
    check({tag, "_ready_other"}, (port == 1) ? req0_ready : req1_ready, 16'd0);
    tick();
    check({tag, "_busy"}, busy, 16'd1);
    tick();
    check({tag, "_rsp_valid"}, (port == 1) ? rsp1_valid : rsp0_valid, 16'd1);
    check({tag, "_rsp_other"}, (port == 1) ? rsp0_valid : rsp1_valid, 16'd0);
    check({tag, "_data"}, rsp_data, exp_data);
    tick();
    check({tag, "_done"}, rsp0_valid | rsp1_valid | busy, 16'd0);
  endtask

  initial begin
    sweep[0]  = '{10'h000, 10'h200, 2'd0, 10'h200};
    sweep[1]  = '{10'h000, 10'h200, 2'd1, 10'h200};
    sweep[2]  = '{10'h000, 10'h200, 2'd2, 10'h000};
    sweep[3]  = '{10'h000, 10'h200, 2'd3, 10'h200};
    sweep[4]  = '{10'h000, 10'h3FF, 2'd0, 10'h3FF};
    sweep[5]  = '{10'h000, 10'h3FF, 2'd1, 10'h001};
    sweep[6]  = '{10'h000, 10'h3FF, 2'd2, 10'h000};
    sweep[7]  = '{10'h000, 10'h3FF, 2'd3, 10'h3FF};
    sweep[8]  = '{10'h3FF, 10'h200, 2'd0, 10'h1FF};
    sweep[9]  = '{10'h3FF, 10'h200, 2'd1, 10'h1FF};
    sweep[10] = '{10'h3FF, 10'h200, 2'd2, 10'h200};
    sweep[11] = '{10'h3FF, 10'h200, 2'd3, 10'h3FF};
    sweep[12] = '{10'h3FF, 10'h3FF, 2'd0, 10'h3FE};
    sweep[13] = '{10'h3FF, 10'h3FF, 2'd1, 10'h000};
    sweep[14] = '{10'h3FF, 10'h3FF, 2'd2, 10'h3FF};
    sweep[15] = '{10'h3FF, 10'h3FF, 2'd3, 10'h3FF};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    check("reset_busy", busy, 16'd0);
    check("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 16'd0);
    check("reset_alu", {alu_op, alu_a}, 16'd0);
    rst_n = 1'b1;

    // Single op on port 0 with explicit latency checks.
    tick();
    req0_valid = 1'b1; req0_a = 10'h3F0; req0_b = 10'h00F; req0_op = 2'd0;
    #1;
    check("single_ready0", req0_ready, 16'd1);
    check("single_ready1", req1_ready, 16'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("single_ready_after", req0_ready, 16'd0);
    check("single_alu_a", alu_a, 16'h3F0);
    check("single_alu_b", alu_b, 16'h00F);
    check("single_alu_op", alu_op, 16'd0);
    check("single_rsp_early", rsp0_valid, 16'd0);
    tick();
    check("single_rsp0_valid", rsp0_valid, 16'd1);
    check("single_rsp1_valid", rsp1_valid, 16'd0);
    check("single_data", rsp_data, 16'h3FF);
    rsp0_ready = 1'b1;
    tick();
    check("single_rsp_cleared", rsp0_valid, 16'd0);
    check("single_idle", busy, 16'd0);
    check("single_alu_hold", alu_a, 16'h3F0);
    rsp0_ready = 1'b0;

    // Non-owner rsp_ready must not complete the transaction.
    req0_valid = 1'b1; req0_a = 10'h010; req0_b = 10'h001; req0_op = 2'd3;
    rsp1_ready = 1'b1;
    #1;
    check("wrong_ready0", req0_ready, 16'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wrong_rsp0_held", rsp0_valid, 16'd1);
      check("wrong_rsp1_low", rsp1_valid, 16'd0);
      tick();
    end
    check("wrong_data", rsp_data, 16'h011);
    rsp0_ready = 1'b1;
    tick();
    check("wrong_done", rsp0_valid | busy, 16'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Asynchronous reset while in EXEC.
    req0_valid = 1'b1; req0_a = 10'h123; req0_b = 10'h111; req0_op = 2'd0;
    tick();
    check("rst_mid_busy", busy, 16'd1);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    #1;
    check("rst_mid_alu_a", alu_a, 16'd0);
    check("rst_mid_alu_b", alu_b, 16'd0);
    check("rst_mid_alu_op", alu_op, 16'd0);
    check("rst_mid_data", rsp_data, 16'd0);
    check("rst_mid_valid", {rsp1_valid, rsp0_valid}, 16'd0);
    check("rst_mid_busy0", busy, 16'd0);
    tick();
    check("rst_mid_no_rsp", rsp0_valid, 16'd0);
    rst_n = 1'b1;

    // Contention straight after reset: pointer is back at port 0.
    req0_valid = 1'b1; req0_a = 10'h001; req0_b = 10'h002; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 10'h3FF; req1_b = 10'h0FF; req1_op = 2'd1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    serve(0, 10'h003, "cont_p0_a");
    serve(1, 10'h300, "cont_p1_a");
    serve(0, 10'h003, "cont_p0_b");
    serve(1, 10'h300, "cont_p1_b");
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on port 1 while port 0 waits.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 10'h005; req1_b = 10'h003; req1_op = 2'd1;
    #1;
    check("bp_ready1", req1_ready, 16'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 10'h020; req0_b = 10'h00A; req0_op = 2'd0;
    #1;
    check("bp_ready0_exec", req0_ready, 16'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_held", rsp1_valid, 16'd1);
      check("bp_data_held", rsp_data, 16'h002);
      check("bp_ready0_blocked", req0_ready, 16'd0);
      check("bp_rsp0_low", rsp0_valid, 16'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_ready0_same_cycle", req0_ready, 16'd0);
    tick();
    check("bp_rsp1_cleared", rsp1_valid, 16'd0);
    rsp0_ready = 1'b1;
    serve(0, 10'h02A, "bp_p0");

    // Op sweep, port 0 only, rsp_ready high: every op issues exactly 3 cycles apart.
    for (int i = 0; i < 16; i++) begin
      req0_a = sweep[i].a; req0_b = sweep[i].b; req0_op = sweep[i].op;
      #1;
      serve(0, sweep[i].exp, $sformatf("sweep%0d", i));
    end
    req0_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
